// File: rtl/i2c_slave_controller.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_slave_controller
//  Description : Oversampled 7-bit-address I2C target with parallel RX/TX data.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2c_slave_controller #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_scl,
    inout  wire        io_sda,
    input  logic [7:0] i_din,
    output logic [7:0] o_dout,
    output logic       o_rx_valid,
    output logic       o_tx_load,
    output logic       o_rw,
    output logic       o_busy,
    output logic       o_start,
    output logic       o_stop,
    output logic [3:0] o_state,
    output logic [3:0] o_bit_count
);

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_ADDR      = 4'd1,
        ST_ADDR_ACK  = 4'd2,
        ST_RX        = 4'd3,
        ST_RX_ACK    = 4'd4,
        ST_TX        = 4'd5,
        ST_TX_ACK    = 4'd6,
        ST_WAIT_STOP = 4'd7
    } state_t;

    localparam logic [3:0] c_last_bit = 4'd7;
    localparam logic [3:0] c_ack_bit  = 4'd8;

    logic       r_scl_meta, r_scl_sync, r_scl_prev;
    logic       r_sda_meta, r_sda_sync, r_sda_prev;

    state_t     r_state, w_state_next;
    logic [3:0] r_bit_count, w_bit_count_next;
    logic [6:0] r_shift, w_shift_next;
    logic [6:0] r_tx_shift, w_tx_shift_next;
    logic       r_sda_low, w_sda_low_next;
    logic       r_phase, w_phase_next;
    logic [7:0] r_dout, w_dout_next;
    logic       r_rx_valid, w_rx_valid_next;
    logic       r_rw, w_rw_next;
    logic       r_busy, w_busy_next;
    logic       r_start, w_start_next;
    logic       r_stop, w_stop_next;
    logic       w_tx_load;

    logic       w_scl_rise, w_scl_fall, w_start_cond, w_stop_cond;
    logic [7:0] w_byte;

    // Sync flops idle high so reset never fabricates a bus edge
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_scl_meta <= 1'b1;
            r_scl_sync <= 1'b1;
            r_scl_prev <= 1'b1;
            r_sda_meta <= 1'b1;
            r_sda_sync <= 1'b1;
            r_sda_prev <= 1'b1;
        end else begin
            r_scl_meta <= i_scl;
            r_scl_sync <= r_scl_meta;
            r_scl_prev <= r_scl_sync;
            r_sda_meta <= io_sda;
            r_sda_sync <= r_sda_meta;
            r_sda_prev <= r_sda_sync;
        end
    end

    assign w_scl_rise   =  r_scl_sync & ~r_scl_prev;
    assign w_scl_fall   = ~r_scl_sync &  r_scl_prev;
    assign w_start_cond =  r_scl_sync &  r_scl_prev &  r_sda_prev & ~r_sda_sync;
    assign w_stop_cond  =  r_scl_sync &  r_scl_prev & ~r_sda_prev &  r_sda_sync;
    assign w_byte       = {r_shift, r_sda_sync};

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_bit_count <= 4'd0;
            r_shift     <= 7'd0;
            r_tx_shift  <= 7'd0;
            r_sda_low   <= 1'b0;
            r_phase     <= 1'b0;
            r_dout      <= 8'd0;
            r_rx_valid  <= 1'b0;
            r_rw        <= 1'b0;
            r_busy      <= 1'b0;
            r_start     <= 1'b0;
            r_stop      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_bit_count <= w_bit_count_next;
            r_shift     <= w_shift_next;
            r_tx_shift  <= w_tx_shift_next;
            r_sda_low   <= w_sda_low_next;
            r_phase     <= w_phase_next;
            r_dout      <= w_dout_next;
            r_rx_valid  <= w_rx_valid_next;
            r_rw        <= w_rw_next;
            r_busy      <= w_busy_next;
            r_start     <= w_start_next;
            r_stop      <= w_stop_next;
        end
    end

    // r_phase marks that the ACK slot's low drive has begun (ADDR_ACK/RX_ACK)
    // or that the master ACKed the last TX byte (TX_ACK).
    always_comb begin
        w_state_next     = r_state;
        w_bit_count_next = r_bit_count;
        w_shift_next     = r_shift;
        w_tx_shift_next  = r_tx_shift;
        w_sda_low_next   = r_sda_low;
        w_phase_next     = r_phase;
        w_dout_next      = r_dout;
        w_rx_valid_next  = 1'b0;
        w_rw_next        = r_rw;
        w_busy_next      = r_busy;
        w_start_next     = 1'b0;
        w_stop_next      = 1'b0;
        w_tx_load        = 1'b0;

        if (w_start_cond) begin
            w_state_next     = ST_ADDR;
            w_sda_low_next   = 1'b0;
            w_start_next     = 1'b1;
            w_busy_next      = 1'b0;
            w_bit_count_next = 4'd0;
            w_phase_next     = 1'b0;
        end else if (w_stop_cond) begin
            w_state_next     = ST_IDLE;
            w_sda_low_next   = 1'b0;
            w_stop_next      = 1'b1;
            w_busy_next      = 1'b0;
            w_bit_count_next = 4'd0;
            w_phase_next     = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_WAIT_STOP: begin
                    w_sda_low_next = 1'b0;
                end
                ST_ADDR: begin
                    if (w_scl_rise) begin
                        w_shift_next = w_byte[6:0];
                        if (r_bit_count == c_last_bit) begin
                            w_bit_count_next = c_ack_bit;
                            w_phase_next     = 1'b0;
                            // General call (all-zero address) is never claimed
                            if (w_byte[7:1] == SLAVE_ADDR && w_byte[7:1] != 7'd0) begin
                                w_state_next = ST_ADDR_ACK;
                                w_rw_next    = w_byte[0];
                                w_busy_next  = 1'b1;
                            end else begin
                                w_state_next = ST_WAIT_STOP;
                            end
                        end else begin
                            w_bit_count_next = r_bit_count + 4'd1;
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    if (w_scl_fall) begin
                        if (!r_phase) begin
                            w_sda_low_next = 1'b1;
                            w_phase_next   = 1'b1;
                        end else begin
                            w_phase_next     = 1'b0;
                            w_bit_count_next = 4'd0;
                            if (r_rw) begin
                                w_state_next    = ST_TX;
                                w_tx_load       = 1'b1;
                                w_tx_shift_next = i_din[6:0];
                                w_sda_low_next  = ~i_din[7];
                            end else begin
                                w_state_next   = ST_RX;
                                w_sda_low_next = 1'b0;
                            end
                        end
                    end
                end
                ST_RX: begin
                    if (w_scl_rise) begin
                        w_shift_next = w_byte[6:0];
                        if (r_bit_count == c_last_bit) begin
                            w_dout_next      = w_byte;
                            w_rx_valid_next  = 1'b1;
                            w_bit_count_next = c_ack_bit;
                            w_phase_next     = 1'b0;
                            w_state_next     = ST_RX_ACK;
                        end else begin
                            w_bit_count_next = r_bit_count + 4'd1;
                        end
                    end
                end
                ST_RX_ACK: begin
                    if (w_scl_fall) begin
                        if (!r_phase) begin
                            w_sda_low_next = 1'b1;
                            w_phase_next   = 1'b1;
                        end else begin
                            w_sda_low_next   = 1'b0;
                            w_phase_next     = 1'b0;
                            w_bit_count_next = 4'd0;
                            w_state_next     = ST_RX;
                        end
                    end
                end
                ST_TX: begin
                    if (w_scl_rise && r_bit_count != c_ack_bit) begin
                        w_bit_count_next = r_bit_count + 4'd1;
                    end
                    if (w_scl_fall) begin
                        if (r_bit_count == c_ack_bit) begin
                            w_sda_low_next = 1'b0;
                            w_phase_next   = 1'b0;
                            w_state_next   = ST_TX_ACK;
                        end else if (r_bit_count != 4'd0) begin
                            w_sda_low_next  = ~r_tx_shift[6];
                            w_tx_shift_next = {r_tx_shift[5:0], 1'b0};
                        end
                    end
                end
                ST_TX_ACK: begin
                    if (w_scl_rise) begin
                        if (r_sda_sync) begin
                            w_sda_low_next = 1'b0;
                            w_busy_next    = 1'b0;
                            w_state_next   = ST_WAIT_STOP;
                        end else begin
                            w_phase_next = 1'b1;
                        end
                    end else if (w_scl_fall && r_phase) begin
                        w_tx_load        = 1'b1;
                        w_tx_shift_next  = i_din[6:0];
                        w_sda_low_next   = ~i_din[7];
                        w_bit_count_next = 4'd0;
                        w_phase_next     = 1'b0;
                        w_state_next     = ST_TX;
                    end
                end
                default: begin
                    w_state_next   = ST_IDLE;
                    w_sda_low_next = 1'b0;
                end
            endcase
        end
    end

    assign io_sda      = r_sda_low ? 1'b0 : 1'bz;
    assign o_dout      = r_dout;
    assign o_rx_valid  = r_rx_valid;
    assign o_tx_load   = w_tx_load & ~i_reset;
    assign o_rw        = r_rw;
    assign o_busy      = r_busy;
    assign o_start     = r_start;
    assign o_stop      = r_stop;
    assign o_state     = r_state;
    assign o_bit_count = r_bit_count;

endmodule
`default_nettype wire

// File: tb/tb_i2c_slave_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i2c_slave_controller
//  Description : Bus-functional I2C master bench with byte scoreboards.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_slave_controller;

    localparam logic [3:0] S_IDLE = 4'd0, S_ADDR_ACK = 4'd2, S_RX_ACK = 4'd4,
                           S_WAIT_STOP = 4'd7;

    logic       clk = 1'b0;
    logic       rst;
    logic       m_scl;
    logic       m_sda_low;
    logic [7:0] din;
    logic [7:0] dout;
    logic       rx_valid, tx_load, rw, busy, start_p, stop_p;
    logic [3:0] state, bit_count;
    wire        sda;

    assign sda = m_sda_low ? 1'b0 : 1'bz;
    pullup (sda);

    always #5 clk = ~clk;

    i2c_slave_controller #(.SLAVE_ADDR(7'h50)) dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_scl       (m_scl),
        .io_sda      (sda),
        .i_din       (din),
        .o_dout      (dout),
        .o_rx_valid  (rx_valid),
        .o_tx_load   (tx_load),
        .o_rw        (rw),
        .o_busy      (busy),
        .o_start     (start_p),
        .o_stop      (stop_p),
        .o_state     (state),
        .o_bit_count (bit_count)
    );

    int n_vec = 0, n_err = 0;
    int start_cnt = 0, stop_cnt = 0, load_cnt = 0, rxv_cnt = 0, dut_low_cnt = 0;
    logic [7:0] rx_q[$];
    logic [7:0] tx_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // Event counters and the RX scoreboard
    always @(negedge clk) begin
        if (start_p)  start_cnt++;
        if (stop_p)   stop_cnt++;
        if (tx_load)  load_cnt++;
        if (!m_sda_low && sda === 1'b0) dut_low_cnt++;
        if (rx_valid) begin
            rxv_cnt++;
            if (rx_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL rx_unexpected: actual dout %02h required no rx_valid", dout);
            end else begin
                check("rx_dout", {24'd0, dout}, {24'd0, rx_q.pop_front()});
            end
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b, output logic r);
        m_scl = 1'b0;      wait_clk(5);
        m_sda_low = ~b;    wait_clk(5);
        m_scl = 1'b1;      wait_clk(5);
        r = sda;           wait_clk(5);
    endtask

    task automatic do_start;
        m_scl = 1'b0;      wait_clk(5);
        m_sda_low = 1'b0;  wait_clk(5);
        m_scl = 1'b1;      wait_clk(5);
        m_sda_low = 1'b1;  wait_clk(5);
    endtask

    task automatic do_stop;
        m_scl = 1'b0;      wait_clk(5);
        m_sda_low = 1'b1;  wait_clk(5);
        m_scl = 1'b1;      wait_clk(5);
        m_sda_low = 1'b0;  wait_clk(10);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack_n);
        logic r;
        for (int i = 7; i >= 0; i--) send_bit(d[i], r);
        send_bit(1'b1, ack_n);
    endtask

    task automatic read_bits(output logic [7:0] d);
        for (int i = 7; i >= 0; i--) send_bit(1'b1, d[i]);
    endtask

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] d0;
        logic [7:0] d1;
        logic       ack;
        logic [3:0] st;
    } wr_vec_t;

    wr_vec_t tbl [6];

    initial begin
        #3000000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1);
    end

    initial begin
        logic       a, r;
        logic [7:0] d;
        int         s0, p0, l0, t0, v0;

        tbl[0] = '{8'hA0, 8'h3C, 8'hC3, 1'b1, S_RX_ACK};
        tbl[1] = '{8'hA4, 8'h55, 8'h00, 1'b0, S_WAIT_STOP};
        tbl[2] = '{8'hA0, 8'hFF, 8'h00, 1'b1, S_RX_ACK};
        tbl[3] = '{8'h00, 8'h12, 8'h34, 1'b0, S_WAIT_STOP};
        tbl[4] = '{8'hA2, 8'hAA, 8'hBB, 1'b0, S_WAIT_STOP};
        tbl[5] = '{8'hA0, 8'h01, 8'h80, 1'b1, S_RX_ACK};

        rst = 1'b1; m_scl = 1'b1; m_sda_low = 1'b0; din = 8'h00;
        wait_clk(4);
        rst = 1'b0;
        wait_clk(2);
        check("rst_state", {28'd0, state}, {28'd0, S_IDLE});
        check("rst_dout", {24'd0, dout}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_rw", {31'd0, rw}, 32'd0);
        check("rst_bitcnt", {28'd0, bit_count}, 32'd0);
        check("rst_sda", {31'd0, sda}, 32'd1);

        // Table-driven write transactions: START, addr, two data bytes, STOP
        for (int i = 0; i < 6; i++) begin
            s0 = start_cnt; p0 = stop_cnt; l0 = dut_low_cnt;
            do_start;
            check("start_pulse", start_cnt - s0, 32'd1);
            write_byte(tbl[i].addr, a);
            check("addr_ack", {31'd0, a}, {31'd0, ~tbl[i].ack});
            if (tbl[i].ack) begin
                check("addr_busy", {31'd0, busy}, 32'd1);
                check("addr_rw", {31'd0, rw}, 32'd0);
                check("addr_state", {28'd0, state}, {28'd0, S_ADDR_ACK});
                rx_q.push_back(tbl[i].d0);
                rx_q.push_back(tbl[i].d1);
            end else begin
                check("nomatch_state", {28'd0, state}, {28'd0, S_WAIT_STOP});
            end
            write_byte(tbl[i].d0, a);
            check("d0_ack", {31'd0, a}, {31'd0, ~tbl[i].ack});
            write_byte(tbl[i].d1, a);
            check("d1_ack", {31'd0, a}, {31'd0, ~tbl[i].ack});
            check("pre_stop_state", {28'd0, state}, {28'd0, tbl[i].st});
            do_stop;
            check("stop_pulse", stop_cnt - p0, 32'd1);
            check("stop_state", {28'd0, state}, {28'd0, S_IDLE});
            check("stop_busy", {31'd0, busy}, 32'd0);
            check("rx_drained", rx_q.size(), 32'd0);
            if (!tbl[i].ack) check("never_driven", dut_low_cnt - l0, 32'd0);
        end

        // Read: ACK first byte, NACK second
        t0 = load_cnt; v0 = rxv_cnt;
        din = 8'hA5; tx_q.push_back(8'hA5);
        do_start;
        write_byte(8'hA1, a);
        check("rd_addr_ack", {31'd0, a}, 32'd0);
        check("rd_rw", {31'd0, rw}, 32'd1);
        read_bits(d);
        check("rd_byte0", {24'd0, d}, {24'd0, tx_q.pop_front()});
        din = 8'h5A; tx_q.push_back(8'h5A);
        send_bit(1'b0, r);
        read_bits(d);
        check("rd_byte1", {24'd0, d}, {24'd0, tx_q.pop_front()});
        send_bit(1'b1, r);
        wait_clk(2);
        check("rd_nack_state", {28'd0, state}, {28'd0, S_WAIT_STOP});
        check("rd_nack_busy", {31'd0, busy}, 32'd0);
        check("rd_nack_sda", {31'd0, sda}, 32'd1);
        check("rd_loads", load_cnt - t0, 32'd2);
        do_stop;
        check("rd_stop_state", {28'd0, state}, {28'd0, S_IDLE});
        check("rd_no_rx", rxv_cnt - v0, 32'd0);

        // Repeated START: write 0x10, Sr, read 0x77 with NACK
        s0 = start_cnt;
        do_start;
        write_byte(8'hA0, a);
        check("sr_rw0", {31'd0, rw}, 32'd0);
        rx_q.push_back(8'h10);
        write_byte(8'h10, a);
        check("sr_d_ack", {31'd0, a}, 32'd0);
        din = 8'h77; tx_q.push_back(8'h77);
        do_start;
        write_byte(8'hA1, a);
        check("sr_addr_ack", {31'd0, a}, 32'd0);
        check("sr_rw1", {31'd0, rw}, 32'd1);
        check("sr_starts", start_cnt - s0, 32'd2);
        read_bits(d);
        check("sr_rd", {24'd0, d}, {24'd0, tx_q.pop_front()});
        send_bit(1'b1, r);
        do_stop;
        check("sr_rx_drained", rx_q.size(), 32'd0);
        check("sr_state", {28'd0, state}, {28'd0, S_IDLE});

        // Abort: STOP after four data bits, then a normal write
        v0 = rxv_cnt;
        do_start;
        write_byte(8'hA0, a);
        for (int i = 0; i < 4; i++) send_bit(1'b1, r);
        do_stop;
        check("abort_no_rx", rxv_cnt - v0, 32'd0);
        check("abort_state", {28'd0, state}, {28'd0, S_IDLE});
        do_start;
        write_byte(8'hA0, a);
        check("abort_reack", {31'd0, a}, 32'd0);
        rx_q.push_back(8'h42);
        write_byte(8'h42, a);
        do_stop;
        check("abort_rx_drained", rx_q.size(), 32'd0);

        // Reset while the address ACK is being driven
        t0 = load_cnt; v0 = rxv_cnt; p0 = stop_cnt;
        do_start;
        for (int i = 7; i >= 0; i--) send_bit(logic'((8'hA1 >> i) & 8'h01), r);
        m_scl = 1'b0;      wait_clk(5);
        m_sda_low = 1'b0;  wait_clk(5);
        m_scl = 1'b1;      wait_clk(3);
        check("rst_mid_ack_low", {31'd0, sda}, 32'd0);
        rst = 1'b1;
        wait_clk(1);
        rst = 1'b0;
        check("rst_mid_sda", {31'd0, sda}, 32'd1);
        check("rst_mid_state", {28'd0, state}, {28'd0, S_IDLE});
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_rw", {31'd0, rw}, 32'd0);
        check("rst_mid_dout", {24'd0, dout}, 32'd0);
        check("rst_mid_bitcnt", {28'd0, bit_count}, 32'd0);
        wait_clk(7);
        read_bits(d);
        check("rst_ignored_rd", {24'd0, d}, 32'hFF);
        send_bit(1'b1, r);
        do_stop;
        check("rst_no_load", load_cnt - t0, 32'd0);
        check("rst_no_rx", rxv_cnt - v0, 32'd0);
        check("rst_stop_pulse", stop_cnt - p0, 32'd1);
        do_start;
        write_byte(8'hA0, a);
        check("rst_reack", {31'd0, a}, 32'd0);
        rx_q.push_back(8'h99);
        write_byte(8'h99, a);
        check("rst_data_ack", {31'd0, a}, 32'd0);
        do_stop;
        check("final_rx_drained", rx_q.size(), 32'd0);
        check("final_tx_drained", tx_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/i2c_slave_controller.md
Name: i2c_slave_controller

Overview:
- I2C target (slave) that answers one 7-bit address on the same bus our i2c_master_controller drives.
- Oversamples SCL/SDA on the system clock and detects START, repeated START and STOP.
- Receives write bytes to a parallel output and serves read bytes from a parallel input.
- Standard-mode and fast-mode capable; no clock stretching (SCL is input-only).

Parameters:
- SLAVE_ADDR, 7'h50, 7-bit address this block acknowledges.

Ports:
- i_clk  in  1  system clock; must be ≥16× the SCL frequency.
- i_reset  in  1  synchronous reset, active-high.
- i_scl  in  1  bus SCL, asynchronous.
- io_sda  inout  1  bus SDA, open-drain: drives 1'b0 or 1'bz, never 1.
- i_din  in  8  read-data byte, sampled in the cycle o_tx_load=1.
- o_dout  out  8  last received write-data byte.
- o_rx_valid  out  1  one-cycle pulse when o_dout is updated.
- o_tx_load  out  1  one-cycle pulse when i_din is captured into the TX shifter.
- o_rw  out  1  R/W bit of the last matched address (1 = read).
- o_busy  out  1  high from address match until STOP, repeated START or NACK exit.
- o_start  out  1  one-cycle pulse on each START or repeated START.
- o_stop  out  1  one-cycle pulse on each STOP.
- o_state  out  4  current FSM state encoding, for debug.
- o_bit_count  out  4  bit index within the current byte, 0..8.

Behaviour:
- Input path:
  - SCL and SDA each pass a 2-FF synchronizer, then one history register. Edges are computed from synchronized current vs. previous values.
  - START = SDA 1→0 while SCL=1. STOP = SDA 0→1 while SCL=1.
  - SDA is sampled on the detected SCL rising edge.
  - The SDA drive value changes only on the detected SCL falling edge. The synchronizer delay supplies the hold time.
- Reset values:
  - SDA released (z). o_dout=0. o_rw=0, o_busy=0.
  - All pulses 0. o_bit_count=0. o_state=IDLE.
  - Reset mid-transfer releases SDA in the next cycle and returns the FSM to IDLE.
- States (encodings 0..7):
  - IDLE: wait for START.
  - ADDR: shift 8 bits, MSB first.
    - After the 8th rising edge: if bits[7:1]==SLAVE_ADDR, go to ADDR_ACK and set o_rw=bit0, o_busy=1.
    - Otherwise go to WAIT_STOP; SDA is never driven.
  - ADDR_ACK: drive SDA=0 from the next SCL fall through the following SCL fall.
    - If o_rw=0, go to RX.
    - If o_rw=1, go to TX: at that same SCL fall, pulse o_tx_load, load i_din, and drive MSB.
  - RX: shift 8 bits. On the 8th rising edge, o_dout updates and o_rx_valid pulses in the next cycle. Go to RX_ACK.
  - RX_ACK: always ACK (drive 0 for one SCL period), then return to RX.
    - No backpressure: the consumer must take o_dout before the next byte completes.
  - TX: drive shifter MSB (0 → drive low, 1 → release) on each SCL fall. After the 8th bit's SCL fall, release SDA and go to TX_ACK.
  - TX_ACK: sample SDA on the rising edge.
    - 0 (ACK): at the next fall, pulse o_tx_load, reload from i_din, go to TX.
    - 1 (NACK): release SDA, clear o_busy, go to WAIT_STOP.
  - WAIT_STOP: SDA released; ignore traffic until START/STOP.
- o_bit_count:
  - Increments on each data/address rising edge.
  - Reads 8 during ACK states.
  - Clears to 0 on entry to ADDR/RX/TX.
- Global overrides, highest priority after reset:
  - START or repeated START in any state: release SDA, pulse o_start, clear o_busy, clear o_bit_count, go to ADDR.
  - STOP in any state: release SDA, pulse o_stop, clear o_busy, go to IDLE.
  - A partially received byte is discarded (no o_rx_valid).
- General call (address 0x00) is not acknowledged.
- START and a same-cycle SCL edge cannot coincide: SCL must be stable high.

Test Plan:
- Write: START, 0xA0, 0x3C, 0xC3, STOP.
  - SDA pulled low on all 3 ACK bits; o_rw=0.
  - o_rx_valid pulses twice with o_dout=0x3C then 0xC3.
  - o_stop pulses; o_busy back to 0; o_state=IDLE.
- Mismatch: START, 0xA4, 0x55, STOP.
  - io_sda never driven (always z); no o_rx_valid.
  - o_state=WAIT_STOP until STOP, then IDLE.
- Read: START, 0xA1, i_din=0xA5 then 0x5A; master ACKs byte 1 and NACKs byte 2.
  - Bus carries 10100101 then 01011010; o_tx_load pulses exactly twice.
  - SDA released after NACK; o_busy=0; state WAIT_STOP.
- Repeated START: START, 0xA0, 0x10, Sr, 0xA1, read i_din=0x77 with NACK, STOP.
  - o_rx_valid with 0x10; o_start pulses twice.
  - o_rw switches 0→1; 0x77 shifted out.
- Abort: STOP after 4 bits of a data byte.
  - No o_rx_valid; IDLE next.
  - A following START+0xA0 is ACKed normally.
- Reset: assert i_reset for 1 cycle while ACK is being driven low.
  - SDA released next cycle; all outputs at reset values.
  - The block ignores the remainder of the transfer until a new START.
